// File: rtl/i2c_multibyte_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_multibyte_master : I2C master that moves 1..2^LEN_W-1 bytes per transfer.
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_multibyte_master #(
   parameter int QDIV  = 125,
   parameter int LEN_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             RW,
   input  logic [6:0]       ADDR,
   input  logic [LEN_W-1:0] LEN,
   input  logic [7:0]       TX_DATA,
   output logic             TX_REQ,
   output logic [7:0]       RX_DATA,
   output logic             RX_VALID,
   output logic             BUSY,
   output logic             DONE,
   output logic             NACK,
   output logic             SCL_O,
   output logic             SDA_O,
   input  logic             SDA_I
);
   localparam logic [15:0]      C_QMAX = 16'(QDIV - 1);
   localparam logic [LEN_W-1:0] C_ONE  = LEN_W'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_MACK, S_STOP
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [15:0]      r_qcnt;
   logic [1:0]       r_phase;
   logic [2:0]       r_bit;
   logic [LEN_W-1:0] r_remain;
   logic [7:0]       r_shift;
   logic             r_rw;
   logic             r_ack_bad;
   logic             r_nack;
   logic             r_done;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;

   logic w_qend;
   logic w_bit_end;
   logic w_sample;
   logic w_tx_first;
   logic w_accept;
   logic w_last;

   assign w_qend     = (r_qcnt == C_QMAX);
   assign w_bit_end  = w_qend && (r_phase == 2'd3);
   assign w_sample   = w_qend && (r_phase == 2'd2);
   assign w_tx_first = (r_state == S_WRITE) && (r_phase == 2'd0) && (r_qcnt == 16'd0) && (r_bit == 3'd7);
   assign w_accept   = (r_state == S_IDLE) && START && (LEN != '0);
   assign w_last     = (r_remain == C_ONE);

   assign TX_REQ   = w_tx_first;
   assign BUSY     = (r_state != S_IDLE);
   assign DONE     = r_done;
   assign NACK     = r_nack;
   assign RX_DATA  = r_rx_data;
   assign RX_VALID = r_rx_valid;

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      SCL_O  = 1'b1;
      SDA_O  = 1'b1;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = S_START;
         S_START: begin
            SCL_O = ~r_phase[1];
            SDA_O = 1'b0;
            if (w_bit_end) w_next = S_ADDR;
         end
         S_ADDR: begin
            SCL_O = r_phase[1];
            SDA_O = r_shift[7];
            if (w_bit_end && r_bit == 3'd0) w_next = S_AACK;
         end
         S_AACK: begin
            SCL_O = r_phase[1];
            if (w_bit_end) w_next = r_ack_bad ? S_STOP : (r_rw ? S_READ : S_WRITE);
         end
         S_WRITE: begin
            // The first bit of a byte is driven straight from TX_DATA while it is being captured.
            SCL_O = r_phase[1];
            SDA_O = w_tx_first ? TX_DATA[7] : r_shift[7];
            if (w_bit_end && r_bit == 3'd0) w_next = S_WACK;
         end
         S_WACK: begin
            SCL_O = r_phase[1];
            if (w_bit_end) w_next = (r_ack_bad || w_last) ? S_STOP : S_WRITE;
         end
         S_READ: begin
            SCL_O = r_phase[1];
            if (w_bit_end && r_bit == 3'd0) w_next = S_MACK;
         end
         S_MACK: begin
            SCL_O = r_phase[1];
            SDA_O = w_last;
            if (w_bit_end) w_next = w_last ? S_STOP : S_READ;
         end
         S_STOP: begin
            SCL_O = (r_phase != 2'd0);
            SDA_O = (r_phase == 2'd3);
            if (w_bit_end) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_qcnt     <= '0;
         r_phase    <= '0;
         r_bit      <= '0;
         r_remain   <= '0;
         r_shift    <= '0;
         r_rw       <= 1'b0;
         r_ack_bad  <= 1'b0;
         r_nack     <= 1'b0;
         r_done     <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_rx_valid <= 1'b0;

         if (r_state == S_IDLE) begin
            r_qcnt  <= '0;
            r_phase <= '0;
         end else if (w_qend) begin
            r_qcnt  <= '0;
            r_phase <= r_phase + 2'd1;
         end else begin
            r_qcnt  <= r_qcnt + 16'd1;
         end

         if (w_accept) begin
            r_rw     <= RW;
            r_shift  <= {ADDR, RW};
            r_remain <= LEN;
            r_nack   <= 1'b0;
            r_bit    <= 3'd7;
         end

         if (w_sample) r_ack_bad <= SDA_I;
         if (w_tx_first) r_shift <= TX_DATA;

         if (r_state == S_READ && w_sample) begin
            r_shift <= {r_shift[6:0], SDA_I};
            if (r_bit == 3'd0) begin
               r_rx_data  <= {r_shift[6:0], SDA_I};
               r_rx_valid <= 1'b1;
            end
         end

         if (w_bit_end) begin
            case (r_state)
               S_ADDR, S_WRITE: begin
                  r_shift <= {r_shift[6:0], 1'b0};
                  r_bit   <= (r_bit == 3'd0) ? 3'd7 : r_bit - 3'd1;
               end
               S_READ: r_bit <= (r_bit == 3'd0) ? 3'd7 : r_bit - 3'd1;
               S_AACK: begin
                  r_bit <= 3'd7;
                  if (r_ack_bad) r_nack <= 1'b1;
               end
               S_WACK: begin
                  r_bit <= 3'd7;
                  if (r_ack_bad)            r_nack   <= 1'b1;
                  else if (r_remain != '0)  r_remain <= r_remain - C_ONE;
               end
               S_MACK: begin
                  r_bit <= 3'd7;
                  if (r_remain != '0) r_remain <= r_remain - C_ONE;
               end
               S_STOP:  r_done <= 1'b1;
               default: ;
            endcase
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_i2c_multibyte_master.sv
`default_nettype none
// tb_i2c_multibyte_master : transfer table plus scoreboard of bus tokens against
// a behavioural slave on a wired-AND SDA line.
module tb_i2c_multibyte_master;
   localparam int          LEN_W     = 4;
   localparam logic [31:0] TOK_START = 32'h1000;
   localparam logic [31:0] TOK_STOP  = 32'h2000;
   localparam logic [4:0]  NONE      = 5'd31;

   logic             CLK = 1'b0;
   logic             RESET, START, RW;
   logic [6:0]       ADDR;
   logic [LEN_W-1:0] LEN;
   logic [7:0]       TX_DATA;
   logic             TX_REQ, RX_VALID, BUSY, DONE, NACK, SCL_O, SDA_O;
   logic [7:0]       RX_DATA;
   logic             slv_sda = 1'b1;
   wire              w_sda_bus = SDA_O & slv_sda;

   i2c_multibyte_master #(.QDIV(2), .LEN_W(LEN_W)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .RW(RW), .ADDR(ADDR), .LEN(LEN),
      .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .BUSY(BUSY), .DONE(DONE), .NACK(NACK), .SCL_O(SCL_O), .SDA_O(SDA_O),
      .SDA_I(w_sda_bus)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic            rw;
      logic [6:0]      addr;
      logic [3:0]      len;
      logic [4:0]      nack_at;   // 0 = address byte, k = data byte k, NONE = always ACK
      logic [15:0][7:0] d;
      logic [4:0]      exp_tx;
      logic [4:0]      exp_rx;
      logic            exp_nack;
   } vec_t;

   vec_t             vtab[7];
   logic [31:0]      exp_q[$];
   logic [7:0]       rx_q[$];
   int               n_chk = 0, n_pass = 0;
   int               txreq_cnt = 0, rxv_cnt = 0, done_cnt = 0, tx_cnt = 0;
   logic [15:0][7:0] tx_tab = '0, rd_tab = '0;
   logic [4:0]       slv_nack_at = NONE;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic obs(input logic [31:0] tok);
      logic [31:0] e;
      if (exp_q.size() == 0) chk("bus_token_extra", tok, 32'hFFFF);
      else begin
         e = exp_q.pop_front();
         chk("bus_token", tok, e);
      end
   endtask

   // Transmit data source, pulse counters and RX scoreboard
   always @(negedge CLK) begin
      TX_DATA = tx_tab[tx_cnt];
      if (TX_REQ) begin
         if (tx_cnt < 15) tx_cnt++;
         txreq_cnt++;
      end
      if (RX_VALID) begin
         rxv_cnt++;
         if (rx_q.size() == 0) chk("rx_extra", 32'(RX_DATA), 32'h100);
         else chk("rx_data", 32'(RX_DATA), 32'(rx_q.pop_front()));
      end
      if (DONE) done_cnt++;
   end

   // Behavioural slave: decodes START/STOP and bytes, answers ACK/NACK, returns read data
   logic scl_q = 1'b1, sda_q = 1'b1, in_xfer = 1'b0, rw_s = 1'b0, tx_act = 1'b0, ack_bit = 1'b0;
   logic [7:0] sh = '0;
   int bitn = 0, bytei = 0;
   always @(negedge CLK) begin : p_slave
      logic scl, sda;
      scl = SCL_O;
      sda = w_sda_bus;
      if (scl && scl_q && sda_q && !sda) begin
         obs(TOK_START);
         in_xfer = 1'b1; bitn = -1; bytei = 0; slv_sda = 1'b1; tx_act = 1'b0;
      end else if (scl && scl_q && !sda_q && sda) begin
         if (in_xfer) obs(TOK_STOP);
         in_xfer = 1'b0; slv_sda = 1'b1;
      end else if (in_xfer && scl && !scl_q) begin
         if (bitn >= 0 && bitn < 8) sh = {sh[6:0], sda};
         else if (bitn == 8)        ack_bit = sda;
      end else if (in_xfer && !scl && scl_q) begin
         if (bitn == -1) bitn = 0;
         else if (bitn < 7) begin
            bitn++;
            if (tx_act) slv_sda = rd_tab[bytei-1][7-bitn];
         end else if (bitn == 7) begin
            bitn = 8;
            if (bytei == 0) rw_s = sh[0];
            if (bytei == 0 || !rw_s) slv_sda = (int'(slv_nack_at) == bytei);
            else                     slv_sda = 1'b1;
         end else begin
            obs({23'd0, ack_bit, sh});
            bitn = 0;
            if (bytei == 0)   tx_act = rw_s && !ack_bit;
            else if (ack_bit) tx_act = 1'b0;
            bytei++;
            slv_sda = tx_act ? rd_tab[bytei-1][7] : 1'b1;
         end
      end
      scl_q = scl;
      sda_q = sda;
   end

   function automatic vec_t mk(input logic rw, input logic [6:0] a, input logic [3:0] l,
                               input logic [4:0] na, input logic [4:0] etx, input logic [4:0] erx,
                               input logic en);
      vec_t v;
      v = '0;
      v.rw = rw; v.addr = a; v.len = l; v.nack_at = na;
      v.exp_tx = etx; v.exp_rx = erx; v.exp_nack = en;
      return v;
   endfunction

   task automatic prepare(input vec_t v);
      tx_tab = v.d; rd_tab = v.d; slv_nack_at = v.nack_at; tx_cnt = 0;
      txreq_cnt = 0; rxv_cnt = 0; done_cnt = 0;
      exp_q.push_back(TOK_START);
      exp_q.push_back({23'd0, v.nack_at == 5'd0, v.addr, v.rw});
      if (v.nack_at != 5'd0) begin
         for (int k = 1; k <= int'(v.len); k++) begin
            if (v.rw) begin
               exp_q.push_back({23'd0, k == int'(v.len), v.d[k-1]});
               rx_q.push_back(v.d[k-1]);
            end else begin
               exp_q.push_back({23'd0, int'(v.nack_at) == k, v.d[k-1]});
               if (int'(v.nack_at) == k) break;
            end
         end
      end
      exp_q.push_back(TOK_STOP);
   endtask

   task automatic launch(input logic rw, input logic [6:0] a, input logic [3:0] l);
      @(negedge CLK);
      START = 1'b1; RW = rw; ADDR = a; LEN = l;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic measure_scl();
      int n;
      n = 0;
      while (!TX_REQ && n < 2000) begin @(negedge CLK); n++; end
      chk("txreq_wait", 32'(TX_REQ), 32'd1);
      n = 0;
      while (!SCL_O && n < 100) begin n++; @(negedge CLK); end
      chk("scl_low_cycles", 32'(n), 32'd4);
      n = 0;
      while (SCL_O && n < 100) begin n++; @(negedge CLK); end
      chk("scl_high_cycles", 32'(n), 32'd4);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int n;
      prepare(v);
      launch(v.rw, v.addr, v.len);
      chk({nm, "_busy"}, 32'(BUSY), 32'd1);
      repeat (6) @(negedge CLK);
      launch(~v.rw, 7'h7F, 4'd1);
      if (v.len == 4'd15) measure_scl();
      n = 0;
      while (!DONE && n < 5000) begin @(negedge CLK); n++; end
      chk({nm, "_done"}, 32'(DONE), 32'd1);
      chk({nm, "_nack"}, 32'(NACK), 32'(v.exp_nack));
      @(negedge CLK);
      chk({nm, "_done_pulse"}, 32'(DONE), 32'd0);
      repeat (10) @(negedge CLK);
      chk({nm, "_txreq_count"}, 32'(txreq_cnt), 32'(v.exp_tx));
      chk({nm, "_rxvalid_count"}, 32'(rxv_cnt), 32'(v.exp_rx));
      chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({nm, "_bus_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      rx_q.delete();
   endtask

   initial begin
      logic seen;
      int   n;
      vtab[0] = mk(1'b0, 7'h48, 4'd2,  NONE, 5'd2,  5'd0, 1'b0);
      vtab[0].d[0] = 8'hA5; vtab[0].d[1] = 8'h3C;
      vtab[1] = mk(1'b1, 7'h1D, 4'd3,  NONE, 5'd0,  5'd3, 1'b0);
      vtab[1].d[0] = 8'h11; vtab[1].d[1] = 8'h22; vtab[1].d[2] = 8'h33;
      vtab[2] = mk(1'b0, 7'h50, 4'd2,  5'd0, 5'd0,  5'd0, 1'b1);
      vtab[2].d[0] = 8'h5A; vtab[2].d[1] = 8'hC3;
      vtab[3] = mk(1'b0, 7'h2A, 4'd4,  5'd2, 5'd2,  5'd0, 1'b1);
      vtab[3].d[0] = 8'h01; vtab[3].d[1] = 8'h02; vtab[3].d[2] = 8'h03; vtab[3].d[3] = 8'h04;
      vtab[4] = mk(1'b0, 7'h33, 4'd15, NONE, 5'd15, 5'd0, 1'b0);
      for (int k = 0; k < 15; k++) vtab[4].d[k] = 8'(k * 19 + 90);
      vtab[5] = mk(1'b1, 7'h6E, 4'd1,  NONE, 5'd0,  5'd1, 1'b0);
      vtab[5].d[0] = 8'hC3;
      vtab[6] = mk(1'b1, 7'h19, 4'd2,  5'd0, 5'd0,  5'd0, 1'b1);

      RESET = 1'b1; START = 1'b0; RW = 1'b0; ADDR = '0; LEN = '0;
      repeat (3) @(negedge CLK);
      chk("rst_scl", 32'(SCL_O), 32'd1);
      chk("rst_sda", 32'(SDA_O), 32'd1);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_nack", 32'(NACK), 32'd0);
      chk("rst_txreq", 32'(TX_REQ), 32'd0);
      chk("rst_rxvalid", 32'(RX_VALID), 32'd0);
      chk("rst_rxdata", 32'(RX_DATA), 32'd0);
      RESET = 1'b0;

      launch(1'b0, 7'h48, 4'd0);
      seen = 1'b0;
      repeat (20) begin
         if (BUSY || DONE) seen = 1'b1;
         @(negedge CLK);
      end
      chk("len0_ignored", 32'(seen), 32'd0);

      for (int i = 0; i < 7; i++) run_vec(vtab[i], $sformatf("vec%0d", i));

      // Reset in bit 5 of the first data byte
      prepare(vtab[0]);
      launch(1'b0, vtab[0].addr, vtab[0].len);
      n = 0;
      while (!TX_REQ && n < 2000) begin @(negedge CLK); n++; end
      chk("rst_mid_txreq_wait", 32'(TX_REQ), 32'd1);
      repeat (18) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      chk("rst_mid_scl", 32'(SCL_O), 32'd1);
      chk("rst_mid_sda", 32'(SDA_O), 32'd1);
      chk("rst_mid_busy", 32'(BUSY), 32'd0);
      chk("rst_mid_rxdata", 32'(RX_DATA), 32'd0);
      RESET = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         if (DONE) seen = 1'b1;
         @(negedge CLK);
      end
      chk("rst_mid_no_done", 32'(seen), 32'd0);
      exp_q.delete();
      rx_q.delete();
      run_vec(vtab[0], "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/i2c_multibyte_master.md
I2C_MULTIBYTE_MASTER -- requirements
Module: i2c_multibyte_master

Interface (parameters)
REQ-001 The module SHALL have parameter QDIV, default 125, meaning CLK cycles per SCL quarter-period (100 kHz at 50 MHz); legal range 2..65535.
REQ-002 The module SHALL have parameter LEN_W, default 4, meaning the width of LEN; a transfer carries 1..2^LEN_W-1 data bytes.

Interface (ports)
REQ-003 The module SHALL have port CLK  input  1  system clock; all logic on posedge.
REQ-004 The module SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port START  input  1  transfer request; sampled only in IDLE.
REQ-006 The module SHALL have port RW  input  1  0 = write, 1 = read; latched with START.
REQ-007 The module SHALL have port ADDR  input  7  target address; latched with START.
REQ-008 The module SHALL have port LEN  input  LEN_W  byte count; latched with START.
REQ-009 The module SHALL have port TX_DATA  input  8  next write byte; sampled in the TX_REQ cycle.
REQ-010 The module SHALL have port TX_REQ  output  1  one-cycle pulse: TX_DATA captured.
REQ-011 The module SHALL have port RX_DATA  output  8  last received byte; held until the next byte completes.
REQ-012 The module SHALL have port RX_VALID  output  1  one-cycle pulse: RX_DATA updated.
REQ-013 The module SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-014 The module SHALL have port DONE  output  1  one-cycle pulse on return to IDLE.
REQ-015 The module SHALL have port NACK  output  1  valid with DONE: transfer aborted on a missing ACK.
REQ-016 The module SHALL have port SCL_O  output  1  0 = drive low, 1 = release.
REQ-017 The module SHALL have port SDA_O  output  1  0 = drive low, 1 = release.
REQ-018 The module SHALL have port SDA_I  input  1  bus SDA level; used only at sample points.

Function
REQ-019 Bit timing SHALL use a quarter counter (0..QDIV-1) and a phase counter (0..3); SCL_O is 0 in phases 0-1 and 1 in phases 2-3; SDA_O changes only on entry to phase 0.
REQ-020 SDA_I SHALL be sampled in the last CLK cycle of phase 2.
REQ-021 States SHALL be IDLE, START, ADDR, AACK, WRITE, WACK, READ, MACK, STOP.
REQ-022 IDLE: SCL_O=1 and SDA_O=1; on START=1 with LEN!=0 the block SHALL latch RW/ADDR/LEN and enter START on the next cycle.
REQ-023 START=1 with LEN=0 SHALL be ignored: no state change and no DONE.
REQ-024 START: SDA_O=0 for 2 quarters with SCL released, then 2 quarters with SCL low, then ADDR.
REQ-025 ADDR: the block SHALL shift {ADDR,RW} MSB-first as 8 bits, then go to AACK.
REQ-026 AACK/WACK: SDA_O=1; sampled SDA_I=1 SHALL set the NACK flag and go to STOP.
REQ-027 AACK with ACK SHALL go to WRITE if RW=0, else to READ.
REQ-028 WRITE: TX_REQ SHALL pulse in the first cycle of each byte's first bit; the captured byte shifts MSB-first, then WACK.
REQ-029 WACK with ACK SHALL decrement the remaining count; remaining=0 goes to STOP, otherwise WRITE.
REQ-030 READ: SDA_O=1; 8 bits shift in MSB-first; RX_DATA updates and RX_VALID pulses in the cycle after the 8th sample; then MACK.
REQ-031 MACK: SDA_O=0 (ACK) if bytes remain after this one, SDA_O=1 (NACK) on the last byte; last goes to STOP, otherwise READ.
REQ-032 STOP: quarter 0 SCL low and SDA low; quarters 1-2 SCL released and SDA low; quarter 3 SDA released; then IDLE.
REQ-033 DONE SHALL pulse in the first IDLE cycle after STOP, NACK SHALL be valid with it, and the NACK flag SHALL clear on the next accepted START.
REQ-034 START asserted while BUSY=1 SHALL be ignored.
REQ-035 The bit counter SHALL count 7 down to 0 and reload on every byte; the byte counter SHALL be LEN_W bits and never wrap below 0.

Reset
REQ-036 On RESET=1 at a CLK edge the block SHALL enter IDLE, clear all counters, and set SCL_O=1, SDA_O=1, BUSY=0, DONE=0, NACK=0, TX_REQ=0, RX_VALID=0, RX_DATA=8'h00.
REQ-037 RESET in mid-transfer SHALL release both lines immediately, without generating a STOP or DONE.

Verification
REQ-038 Write: ADDR=7'h48, RW=0, LEN=2, bytes A5/3C, slave ACKs all -> bus shows START, 0x90, ACK, A5, ACK, 3C, ACK, STOP; TX_REQ pulses exactly 2 times; DONE=1 with NACK=0.
REQ-039 Read: ADDR=7'h1D, RW=1, LEN=3, slave sends 11/22/33 -> RX_VALID pulses 3 times with 11, 22, 33; master ACK, ACK, NACK; STOP; DONE=1.
REQ-040 Address NACK: SDA_I=1 at AACK -> STOP immediately, no TX_REQ, DONE=1 with NACK=1.
REQ-041 Data NACK: LEN=4, slave NACKs byte 2 -> STOP after WACK 2, TX_REQ count=2, NACK=1.
REQ-042 QDIV=2, LEN=15: SCL high and low each exactly 4 CLK cycles; 15 bytes transferred; START during BUSY ignored; LEN=0 ignored.
REQ-043 RESET asserted during bit 5 of byte 1 -> next cycle SCL_O=1, SDA_O=1, BUSY=0, no DONE pulse; a new transfer then completes normally.
